// File: rtl/memory_z_pkg.sv
// Shared encodings for the memory_z triple-buffer scheduler.
// Slice states, read FSM codes and slice pointer rotation.
package memory_z_pkg;

  typedef enum logic [1:0] {
    S_FREE  = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2,
    S_DRAIN = 2'd3
  } slc_st_e;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_ISSUE = 2'd1;
  localparam logic [1:0] R_FLUSH = 2'd2;

  localparam logic [1:0] SLC_NONE = 2'b11;

  // 0->1->2->0; the unused code falls back to slice 0
  function automatic logic [1:0] ptr_next(
    input logic [1:0] p
  );
    if (p == 2'd2 || p == SLC_NONE)
      return 2'd0;
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/memory_z_sched_rd_pipe.sv
// Read-side sideband delay line: carries {valid,last}
// alongside the memory_z read latency.
module z_rd_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_last,
  output logic out_valid,
  output logic out_last
);

  logic [RD_LAT-1:0] v_q, v_d;
  logic [RD_LAT-1:0] l_q, l_d;

  always_comb begin
    v_d    = v_q;
    l_d    = l_q;
    v_d[0] = in_valid;
    l_d[0] = in_last;
    for (int i = 1; i < RD_LAT; i++) begin
      v_d[i] = v_q[i-1];
      l_d[i] = l_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      l_q <= '0;
    end else begin
      v_q <= v_d;
      l_q <= l_d;
    end
  end

  assign out_valid = v_q[RD_LAT-1];
  assign out_last  = l_q[RD_LAT-1];

endmodule

// File: rtl/memory_z_sched.sv
// Triple-buffer scheduler for memory_z: producer fills one
// slice while the consumer drains another, rotating 0->1->2.
module memory_z_sched
  import memory_z_pkg::*;
#(
  parameter int DW     = 24,
  parameter int AW     = 6,
  parameter int DEPTH  = 40,
  parameter int NSLC   = 3,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          rd_req,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic [1:0]    full_cnt,
  output logic [AW-1:0] mem_wraddr,
  output logic [1:0]    mem_wrslc,
  output logic          mem_wren,
  output logic [DW-1:0] mem_in,
  output logic [AW-1:0] mem_rdaddr,
  output logic [1:0]    mem_rdslc,
  input  logic [DW-1:0] mem_rdout
);

  localparam logic [AW-1:0] WLAST = AW'(DEPTH - 1);
  localparam logic [1:0]    FLAT  = 2'(RD_LAT - 1);

  slc_st_e       st_q  [NSLC];
  slc_st_e       st_d  [NSLC];
  logic [AW-1:0] len_q [NSLC];
  logic [AW-1:0] len_d [NSLC];

  logic [1:0]    wr_ptr_q, wr_ptr_d;
  logic [1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [1:0]    rstate_q, rstate_d;
  logic [1:0]    fcnt_q, fcnt_d;

  logic          wren_q, wren_d;
  logic [AW-1:0] wraddr_q, wraddr_d;
  logic [1:0]    wrslc_q, wrslc_d;
  logic [DW-1:0] win_q, win_d;

  logic hs, close, iss_v, iss_l;
  logic pv, pl;

  assign in_ready = (st_q[wr_ptr_q] == S_FREE)
                 || (st_q[wr_ptr_q] == S_FILL);
  assign hs    = in_valid && in_ready;
  assign close = hs && (in_last || wcnt_q == WLAST);

  always_comb begin
    st_d     = st_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    wcnt_d   = wcnt_q;
    wren_d   = hs;
    wraddr_d = hs ? wcnt_q   : '0;
    wrslc_d  = hs ? wr_ptr_q : '0;
    win_d    = hs ? in_data  : '0;
    if (close) begin
      st_d[wr_ptr_q]  = S_FULL;
      len_d[wr_ptr_q] = wcnt_q + AW'(1);
      wr_ptr_d        = ptr_next(wr_ptr_q);
      wcnt_d          = '0;
    end else if (hs) begin
      st_d[wr_ptr_q] = S_FILL;
      wcnt_d         = wcnt_q + AW'(1);
    end

    // read side only touches FULL/DRAIN slices, so
    // it never collides with the write-side update
    rstate_d = rstate_q;
    raddr_d  = raddr_q;
    fcnt_d   = fcnt_q;
    rd_ptr_d = rd_ptr_q;
    iss_v    = 1'b0;
    iss_l    = 1'b0;
    unique case (rstate_q)
      R_IDLE: begin
        if (rd_req && st_q[rd_ptr_q] == S_FULL) begin
          rstate_d       = R_ISSUE;
          st_d[rd_ptr_q] = S_DRAIN;
          raddr_d        = '0;
        end
      end
      R_ISSUE: begin
        iss_v = 1'b1;
        iss_l = raddr_q == len_q[rd_ptr_q] - AW'(1);
        if (iss_l) begin
          rstate_d = R_FLUSH;
          raddr_d  = '0;
          fcnt_d   = '0;
        end else begin
          raddr_d = raddr_q + AW'(1);
        end
      end
      R_FLUSH: begin
        if (fcnt_q == FLAT) begin
          st_d[rd_ptr_q] = S_FREE;
          rd_ptr_d       = ptr_next(rd_ptr_q);
          rstate_d       = R_IDLE;
          fcnt_d         = '0;
        end else begin
          fcnt_d = fcnt_q + 2'd1;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    full_cnt = '0;
    for (int i = 0; i < NSLC; i++)
      if (st_q[i] == S_FULL)
        full_cnt = full_cnt + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLC; i++) begin
        st_q[i]  <= S_FREE;
        len_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wcnt_q   <= '0;
      raddr_q  <= '0;
      rstate_q <= R_IDLE;
      fcnt_q   <= '0;
      wren_q   <= 1'b0;
      wraddr_q <= '0;
      wrslc_q  <= '0;
      win_q    <= '0;
    end else begin
      st_q     <= st_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wcnt_q   <= wcnt_d;
      raddr_q  <= raddr_d;
      rstate_q <= rstate_d;
      fcnt_q   <= fcnt_d;
      wren_q   <= wren_d;
      wraddr_q <= wraddr_d;
      wrslc_q  <= wrslc_d;
      win_q    <= win_d;
    end
  end

  z_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (iss_v),
    .in_last   (iss_l),
    .out_valid (pv),
    .out_last  (pl)
  );

  assign out_valid  = pv;
  assign out_last   = pl;
  assign out_data   = pv ? mem_rdout : '0;
  assign mem_wren   = wren_q;
  assign mem_wraddr = wraddr_q;
  assign mem_wrslc  = wrslc_q;
  assign mem_in     = win_q;
  assign mem_rdaddr = iss_v ? raddr_q  : '0;
  assign mem_rdslc  = iss_v ? rd_ptr_q : '0;

endmodule

// File: tb/tb_memory_z_sched.sv
// Self-checking bench for memory_z_sched with a behavioural
// memory_z model and write/read scoreboards.
module tb_memory_z_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        rd_req = 1'b0;
  logic        out_valid;
  logic [23:0] out_data;
  logic        out_last;
  logic [1:0]  full_cnt;
  logic [5:0]  mem_wraddr;
  logic [1:0]  mem_wrslc;
  logic        mem_wren;
  logic [23:0] mem_in;
  logic [5:0]  mem_rdaddr;
  logic [1:0]  mem_rdslc;
  logic [23:0] mem_rdout;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  s;
    logic [5:0]  a;
    logic [23:0] d;
  } wexp_t;

  typedef struct packed {
    logic [23:0] d;
    logic        l;
  } rexp_t;

  typedef struct packed {
    logic        v;
    logic [23:0] d;
    logic        l;
    logic        rd;
    logic        rdy;
    logic        wr;
    logic [1:0]  s;
    logic [5:0]  a;
    logic [1:0]  fc;
  } vec_t;

  wexp_t wq[$];
  rexp_t rq[$];
  wexp_t we;
  rexp_t re;

  logic [23:0] ram [256];
  logic [23:0] rd_q = '0;

  memory_z_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .rd_req     (rd_req),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .full_cnt   (full_cnt),
    .mem_wraddr (mem_wraddr),
    .mem_wrslc  (mem_wrslc),
    .mem_wren   (mem_wren),
    .mem_in     (mem_in),
    .mem_rdaddr (mem_rdaddr),
    .mem_rdslc  (mem_rdslc),
    .mem_rdout  (mem_rdout)
  );

  always #5 clk = ~clk;

  // memory_z model: 3 slices at offsets 0/40/80, 1-cycle read
  always @(posedge clk) begin
    if (mem_wren)
      ram[int'(mem_wrslc) * 40 + int'(mem_wraddr)] <= mem_in;
    rd_q <= ram[int'(mem_rdslc) * 40 + int'(mem_rdaddr)];
  end
  assign mem_rdout = rd_q;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_wren) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write act=%0h exp=none",
                   {mem_wrslc, mem_wraddr, mem_in});
        end else begin
          we = wq.pop_front();
          chk("wr_slc", 32'(mem_wrslc), 32'(we.s));
          chk("wr_addr", 32'(mem_wraddr), 32'(we.a));
          chk("wr_data", 32'(mem_in), 32'(we.d));
        end
      end else begin
        chk("wraddr_idle", 32'(mem_wraddr), 32'd0);
      end
      if (out_valid) begin
        if (rq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read act=%0h exp=none",
                   out_data);
        end else begin
          re = rq.pop_front();
          chk("rd_data", 32'(out_data), 32'(re.d));
          chk("rd_last", 32'(out_last), 32'(re.l));
        end
      end else begin
        chk("out_data_idle", 32'(out_data), 32'd0);
      end
    end
  end

  task automatic drive_word(input logic [23:0] d,
                            input logic l,
                            input logic [1:0] s,
                            input logic [5:0] a);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    wq.push_back('{s: s, a: a, d: d});
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic push_rd(input logic [23:0] d, input logic l);
    rq.push_back('{d: d, l: l});
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic wait_rq(input int budget);
    int n = 0;
    while (rq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(rq.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    rd_req   = 1'b0;
    rst_n    = 1'b0;
    wq.delete();
    rq.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

  vec_t tv [14];

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;

    tv[0]  = '{1'b1, 24'h11, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 6'd0, 2'd0};
    tv[1]  = '{1'b1, 24'h12, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 6'd1, 2'd1};
    tv[2]  = '{1'b1, 24'h21, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 6'd0, 2'd1};
    tv[3]  = '{1'b1, 24'h22, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 6'd1, 2'd2};
    tv[4]  = '{1'b1, 24'h31, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 6'd0, 2'd2};
    tv[5]  = '{1'b1, 24'h32, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 6'd1, 2'd3};
    tv[6]  = '{1'b1, 24'h99, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 2'd3};
    tv[7]  = '{1'b1, 24'h99, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 2'd3};
    tv[8]  = '{1'b1, 24'h41, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 6'd0, 2'd2};
    tv[9]  = '{1'b1, 24'h41, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 2'd2};
    tv[10] = '{1'b1, 24'h41, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 2'd2};
    tv[11] = '{1'b1, 24'h41, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd0, 2'd2};
    tv[12] = '{1'b1, 24'h41, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 6'd0, 2'd2};
    tv[13] = '{1'b1, 24'h42, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 6'd1, 2'd3};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren), 32'd0);
    chk("rst_full_cnt", 32'(full_cnt), 32'd0);
    chk("rst_rdslc", 32'(mem_rdslc), 32'd0);
    chk("rst_wrslc", 32'(mem_wrslc), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    tick();

    // forced close at DEPTH words, 41st word rolls to slice 1
    for (int i = 0; i < 41; i++) begin
      drive_word(24'(100 + i), 1'b0,
                 (i < 40) ? 2'd0 : 2'd1,
                 (i < 40) ? 6'(i) : 6'd0);
      if (i == 39)
        chk("t2_fc_close", 32'(full_cnt), 32'd1);
    end
    chk("t2_fc_after", 32'(full_cnt), 32'd1);
    for (int a = 0; a < 40; a++)
      push_rd(24'(100 + a), a == 39);
    pulse_rd();
    wait_rq(80);
    do_reset();

    // short layer, then drain with cycle-exact address/valid
    for (int i = 0; i < 5; i++)
      drive_word(24'(i + 1), i == 4, 2'd0, 6'(i));
    chk("t3_fc_full", 32'(full_cnt), 32'd1);
    for (int i = 0; i < 5; i++)
      push_rd(24'(i + 1), i == 4);
    pulse_rd();
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      chk("t3_rdaddr", 32'(mem_rdaddr), (j < 5) ? 32'(j) : 32'd0);
      chk("t3_rdslc", 32'(mem_rdslc), 32'd0);
      chk("t3_oval", 32'(out_valid), 32'(j >= 1 && j <= 5));
      chk("t3_olast", 32'(out_last), 32'(j == 5));
      if (j == 0)
        chk("t3_fc_drain", 32'(full_cnt), 32'd0);
      tick();
    end
    chk("t3_rq_empty", 32'(rq.size()), 32'd0);
    rd_req = 1'b1;
    repeat (3) tick();
    rd_req = 1'b0;
    @(negedge clk);
    chk("t3_noslice_oval", 32'(out_valid), 32'd0);
    chk("t3_noslice_addr", 32'(mem_rdaddr), 32'd0);
    chk("t3_in_ready", 32'(in_ready), 32'd1);
    do_reset();

    // all slices full, then release one
    push_rd(24'h11, 1'b0);
    push_rd(24'h12, 1'b1);
    for (int i = 0; i < 14; i++) begin
      in_valid = tv[i].v;
      in_data  = tv[i].d;
      in_last  = tv[i].l;
      rd_req   = tv[i].rd;
      if (tv[i].wr)
        wq.push_back('{s: tv[i].s, a: tv[i].a, d: tv[i].d});
      @(negedge clk);
      chk("t4_ready", 32'(in_ready), 32'(tv[i].rdy));
      tick();
      chk("t4_fcnt", 32'(full_cnt), 32'(tv[i].fc));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    rd_req   = 1'b0;
    wait_rq(10);
    do_reset();

    // close slice 1 on the edge slice 0 starts draining
    drive_word(24'h501, 1'b0, 2'd0, 6'd0);
    drive_word(24'h502, 1'b0, 2'd0, 6'd1);
    drive_word(24'h503, 1'b1, 2'd0, 6'd2);
    drive_word(24'h511, 1'b0, 2'd1, 6'd0);
    push_rd(24'h501, 1'b0);
    push_rd(24'h502, 1'b0);
    push_rd(24'h503, 1'b1);
    rd_req   = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'h512;
    in_last  = 1'b1;
    wq.push_back('{s: 2'd1, a: 6'd1, d: 24'h512});
    @(negedge clk);
    chk("t5_fc_pre", 32'(full_cnt), 32'd1);
    tick();
    rd_req   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("t5_fc_post", 32'(full_cnt), 32'd1);
    wait_rq(20);
    push_rd(24'h511, 1'b0);
    push_rd(24'h512, 1'b1);
    rd_req   = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'h521;
    wq.push_back('{s: 2'd2, a: 6'd0, d: 24'h521});
    tick();
    rd_req   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_rdslc", 32'(mem_rdslc), 32'd1);
    chk("t5_rdaddr", 32'(mem_rdaddr), 32'd0);
    wait_rq(20);
    do_reset();

    // reset while draining word 3 of 10 and writing
    for (int i = 0; i < 10; i++)
      drive_word(24'(24'h600 + i), i == 9, 2'd0, 6'(i));
    for (int i = 0; i < 10; i++)
      push_rd(24'(24'h600 + i), i == 9);
    rd_req   = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'h700;
    wq.push_back('{s: 2'd1, a: 6'd0, d: 24'h700});
    tick();
    rd_req  = 1'b0;
    in_data = 24'h701;
    wq.push_back('{s: 2'd1, a: 6'd1, d: 24'h701});
    tick();
    in_data = 24'h702;
    wq.push_back('{s: 2'd1, a: 6'd2, d: 24'h702});
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    chk("t6_oval_pre", 32'(out_valid), 32'd1);
    chk("t6_wren_pre", 32'(mem_wren), 32'd1);
    chk("t6_rdaddr_pre", 32'(mem_rdaddr), 32'd2);
    rst_n = 1'b0;
    wq.delete();
    rq.delete();
    #1;
    chk("t6_oval_rst", 32'(out_valid), 32'd0);
    chk("t6_wren_rst", 32'(mem_wren), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("t6_fc", 32'(full_cnt), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    drive_word(24'h777, 1'b1, 2'd0, 6'd0);
    push_rd(24'h777, 1'b1);
    pulse_rd();
    wait_rq(10);

    chk("end_wq_empty", 32'(wq.size()), 32'd0);
    chk("end_rq_empty", 32'(rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
